// File: rtl/wpt_pkg.sv
// Shared types and default parameters for the WPT transceiver sequencer.
// Holds the per-channel state encoding and the default timing constants.
package wpt_pkg;

    typedef enum logic [2:0] {
        ST_OFF    = 3'd0,
        ST_SETTLE = 3'd1,
        ST_RX     = 3'd2,
        ST_GUARD  = 3'd3,
        ST_TX     = 3'd4
    } ch_state_t;

    localparam int DEF_NCH    = 2;
    localparam int DEF_DEB    = 3;
    localparam int DEF_GUARD  = 4;
    localparam int DEF_SETTLE = 16;

endpackage

// File: rtl/wpt_ch_fsm.sv
// One RF front-end channel: request debouncer, OFF/SETTLE/RX/GUARD/TX sequencer,
// shared settle/guard counter and sticky TX bias-loss fault bit.
module wpt_ch_fsm
    import wpt_pkg::*;
#(
    parameter int DEB    = DEF_DEB,
    parameter int GUARD  = DEF_GUARD,
    parameter int SETTLE = DEF_SETTLE
) (
    input  logic      clk_i,
    input  logic      rst_n,
    input  logic      en_i,
    input  logic      bias_ok_i,
    input  logic      req_sync_i,
    input  logic      fault_clr_i,
    output logic      lna_en_o,
    output logic      pa_en_o,
    output logic      busy_o,
    output logic      fault_o,
    output ch_state_t state_o
);

    localparam int CMAX0 = (GUARD > SETTLE) ? GUARD : SETTLE;
    localparam int CMAX  = (CMAX0 > DEB) ? CMAX0 : DEB;
    localparam int CW    = $clog2(CMAX + 1);

    ch_state_t     state_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_inc;
    logic [CW-1:0] cnt_end;
    logic [CW-1:0] dcnt_q;
    logic [CW-1:0] dcnt_d;
    logic          deb_q;
    logic          deb_d;
    logic          lna_q;
    logic          pa_q;
    logic          busy_q;
    logic          fault_q;
    logic          fault_set;

    // The FSM acts on deb_d so a request change is seen in the cycle it is accepted.
    always_comb begin
        deb_d  = deb_q;
        dcnt_d = '0;
        if (req_sync_i != deb_q) begin
            if (dcnt_q == CW'(DEB - 1)) begin
                deb_d = req_sync_i;
            end else begin
                dcnt_d = (dcnt_q == '1) ? dcnt_q : dcnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        cnt_end   = (state_q == ST_SETTLE) ? CW'(SETTLE - 1) : CW'(GUARD - 1);
        fault_set = (state_q == ST_TX) && !bias_ok_i;
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_OFF;
            cnt_q   <= '0;
            dcnt_q  <= '0;
            deb_q   <= 1'b0;
            lna_q   <= 1'b0;
            pa_q    <= 1'b0;
            busy_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            deb_q   <= deb_d;
            dcnt_q  <= dcnt_d;
            fault_q <= (fault_q & ~fault_clr_i) | fault_set;
            lna_q   <= 1'b0;
            pa_q    <= 1'b0;
            busy_q  <= 1'b0;
            // Enable or bias loss overrides every other transition.
            if (!en_i || !bias_ok_i) begin
                state_q <= ST_OFF;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    ST_OFF: begin
                        state_q <= ST_SETTLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                    ST_SETTLE, ST_GUARD: begin
                        if (cnt_q == cnt_end) begin
                            state_q <= deb_d ? ST_RX : ST_TX;
                            cnt_q   <= '0;
                            lna_q   <= deb_d;
                            pa_q    <= ~deb_d;
                        end else begin
                            cnt_q  <= cnt_inc;
                            busy_q <= 1'b1;
                        end
                    end
                    ST_RX: begin
                        if (!deb_d) begin
                            state_q <= ST_GUARD;
                            cnt_q   <= '0;
                            busy_q  <= 1'b1;
                        end else begin
                            lna_q <= 1'b1;
                        end
                    end
                    ST_TX: begin
                        if (deb_d) begin
                            state_q <= ST_GUARD;
                            cnt_q   <= '0;
                            busy_q  <= 1'b1;
                        end else begin
                            pa_q <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= ST_OFF;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign lna_en_o = lna_q;
    assign pa_en_o  = pa_q;
    assign busy_o   = busy_q;
    assign fault_o  = fault_q;
    assign state_o  = state_q;

endmodule

// File: rtl/wpt_trx_seq.sv
// WPT transceiver sequencer top: synchronises bias flags and mode requests,
// then runs one independent wpt_ch_fsm per RF channel.
module wpt_trx_seq
    import wpt_pkg::*;
#(
    parameter int NCH    = DEF_NCH,
    parameter int DEB    = DEF_DEB,
    parameter int GUARD  = DEF_GUARD,
    parameter int SETTLE = DEF_SETTLE
) (
    input  logic                 wb_clk_i,
    input  logic                 rst_n,
    input  logic                 en_i,
    input  logic [3:0]           vbias_i,
    input  logic [NCH-1:0]       vswp_i,
    input  logic                 fault_clr_i,
    output logic [NCH-1:0]       lna_en_o,
    output logic [NCH-1:0]       pa_en_o,
    output logic [NCH-1:0]       busy_o,
    output logic [NCH-1:0]       fault_o,
    output ch_state_t [NCH-1:0]  dbg_state_o
);

    logic [3:0]     vbias_s1_q;
    logic [3:0]     vbias_s2_q;
    logic [NCH-1:0] vswp_s1_q;
    logic [NCH-1:0] vswp_s2_q;
    logic           bias_ok;

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            vbias_s1_q <= '0;
            vbias_s2_q <= '0;
            vswp_s1_q  <= '0;
            vswp_s2_q  <= '0;
        end else begin
            vbias_s1_q <= vbias_i;
            vbias_s2_q <= vbias_s1_q;
            vswp_s1_q  <= vswp_i;
            vswp_s2_q  <= vswp_s1_q;
        end
    end

    assign bias_ok = &vbias_s2_q;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        wpt_ch_fsm #(
            .DEB    (DEB),
            .GUARD  (GUARD),
            .SETTLE (SETTLE)
        ) u_ch (
            .clk_i       (wb_clk_i),
            .rst_n       (rst_n),
            .en_i        (en_i),
            .bias_ok_i   (bias_ok),
            .req_sync_i  (vswp_s2_q[g]),
            .fault_clr_i (fault_clr_i),
            .lna_en_o    (lna_en_o[g]),
            .pa_en_o     (pa_en_o[g]),
            .busy_o      (busy_o[g]),
            .fault_o     (fault_o[g]),
            .state_o     (dbg_state_o[g])
        );
    end

endmodule

// File: tb/tb_wpt_trx_seq.sv
// Directed bench for wpt_trx_seq: power-up, glitch, mode switch, guard reversal,
// TX bias loss with fault clear, asynchronous reset mid-TX and enable drop.
module tb_wpt_trx_seq;
  import wpt_pkg::*;

  logic                 clk;
  logic                 rst_n;
  logic                 en;
  logic [3:0]           vbias;
  logic [1:0]           vswp;
  logic                 fault_clr;
  logic [1:0]           lna;
  logic [1:0]           pa;
  logic [1:0]           busy;
  logic [1:0]           fault;
  ch_state_t [1:0]      dbg_state;

  int n_checks;
  int n_fail;
  int overlap_cnt;

  wpt_trx_seq dut (
    .wb_clk_i    (clk),
    .rst_n       (rst_n),
    .en_i        (en),
    .vbias_i     (vbias),
    .vswp_i      (vswp),
    .fault_clr_i (fault_clr),
    .lna_en_o    (lna),
    .pa_en_o     (pa),
    .busy_o      (busy),
    .fault_o     (fault),
    .dbg_state_o (dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // LNA and PA of a channel must never be on together
  always @(negedge clk) begin
    if ((lna & pa) != 2'b00) overlap_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // advance n rising edges, then step off the edge
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    overlap_cnt = 0;
    rst_n       = 1'b0;
    en          = 1'b0;
    vbias       = 4'h0;
    vswp        = 2'b00;
    fault_clr   = 1'b0;

    tick(3);
    check("rst_lna",   32'(lna),   32'h0);
    check("rst_pa",    32'(pa),    32'h0);
    check("rst_busy",  32'(busy),  32'h0);
    check("rst_fault", 32'(fault), 32'h0);

    // power-up into RX on both channels
    rst_n = 1'b1;
    en    = 1'b1;
    vbias = 4'hF;
    vswp  = 2'b11;
    tick(18);
    check("pwr_lna_early",  32'(lna),  32'h0);
    check("pwr_busy_early", 32'(busy), 32'h3);
    tick(1);
    check("pwr_lna",   32'(lna),  32'h3);
    check("pwr_pa",    32'(pa),   32'h0);
    check("pwr_busy",  32'(busy), 32'h0);
    check("pwr_state", 32'(dbg_state[0]), 32'(ST_RX));

    // 2-cycle glitch on ch0 request, shorter than debounce
    vswp = 2'b10;
    tick(2);
    vswp = 2'b11;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      check("glitch_lna", 32'(lna), 32'h3);
    end
    check("glitch_busy", 32'(busy), 32'h0);

    // ch0 RX -> TX
    vswp = 2'b10;
    tick(4);
    check("sw_lna_hold", 32'(lna), 32'h3);
    tick(1);
    check("sw_lna_drop", 32'(lna),  32'h2);
    check("sw_busy",     32'(busy), 32'h1);
    tick(3);
    check("sw_pa_wait",  32'(pa),   32'h0);
    tick(1);
    check("sw_pa_rise",  32'(pa),   32'h1);
    check("sw_lna_ch1",  32'(lna),  32'h2);
    check("sw_busy_end", 32'(busy), 32'h0);

    // ch1 request returns to RX while in GUARD
    vswp = 2'b00;
    tick(4);
    vswp = 2'b10;
    tick(1);
    check("rev_lna_drop", 32'(lna),  32'h0);
    check("rev_busy",     32'(busy), 32'h2);
    tick(3);
    check("rev_in_guard", 32'(lna | pa), 32'h1);
    tick(1);
    check("rev_lna",  32'(lna),  32'h2);
    check("rev_pa",   32'(pa),   32'h1);
    check("rev_busy_end", 32'(busy), 32'h0);

    // swap: ch0 -> RX, ch1 -> TX
    vswp = 2'b01;
    tick(9);
    check("swap_lna", 32'(lna), 32'h1);
    check("swap_pa",  32'(pa),  32'h2);

    // bias loss: fault only on the TX channel
    vbias = 4'h7;
    tick(2);
    check("bl_pa_hold", 32'(pa), 32'h2);
    tick(1);
    check("bl_pa",    32'(pa),    32'h0);
    check("bl_lna",   32'(lna),   32'h0);
    check("bl_fault", 32'(fault), 32'h2);
    tick(1);
    check("bl_fault_sticky", 32'(fault), 32'h2);
    fault_clr = 1'b1;
    tick(1);
    fault_clr = 1'b0;
    check("bl_fault_clr", 32'(fault), 32'h0);

    // bias back: full SETTLE then ch0 RX, ch1 TX
    vbias = 4'hF;
    tick(19);
    check("rb_lna", 32'(lna), 32'h1);
    check("rb_pa",  32'(pa),  32'h2);

    // asynchronous reset mid-TX
    #2 rst_n = 1'b0;
    #1;
    check("ar_pa",   32'(pa),   32'h0);
    check("ar_lna",  32'(lna),  32'h0);
    check("ar_busy", 32'(busy), 32'h0);
    tick(2);
    rst_n = 1'b1;
    tick(18);
    check("ar_pa_early", 32'(pa),   32'h0);
    check("ar_busy_set", 32'(busy), 32'h3);
    tick(1);
    check("ar_lna_re", 32'(lna), 32'h1);
    check("ar_pa_re",  32'(pa),  32'h2);

    // enable drop from TX: off next cycle, no fault
    en = 1'b0;
    tick(1);
    check("en_lna",   32'(lna),   32'h0);
    check("en_pa",    32'(pa),    32'h0);
    check("en_fault", 32'(fault), 32'h0);
    check("en_state", 32'(dbg_state[1]), 32'(ST_OFF));

    check("no_overlap", 32'(overlap_cnt), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
